// File: rtl/sdram_cache_pkg.sv
// Shared constants and FSM state encoding for the single-line SDRAM byte cache.
package sdram_cache_pkg;
  localparam int ADDR_W_DEF = 21;
  localparam int LINE_BYTES = 8;
  localparam int IDX_W      = 3;
  localparam int TAG_W      = ADDR_W_DEF - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_EVICT_REQ,
    S_EVICT_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/sdram_line_buf.sv
// 8x8 line storage: host byte write port, burst capture port, two async read ports.
module sdram_line_buf
  import sdram_cache_pkg::*;
#(
  parameter int DEPTH = LINE_BYTES
) (
  input  logic             clk,
  input  logic             a_we,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [7:0]       a_wdata,
  output logic [7:0]       a_rdata,
  input  logic             b_we,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [7:0]       b_wdata,
  output logic [7:0]       b_rdata
);
  logic [7:0] bytes_q [DEPTH];

  // The two ports are never enabled in the same state, so their order is irrelevant.
  always_ff @(posedge clk) begin
    if (b_we) bytes_q[b_idx] <= b_wdata;
    if (a_we) bytes_q[a_idx] <= a_wdata;
  end

  assign a_rdata = bytes_q[a_idx];
  assign b_rdata = bytes_q[b_idx];
endmodule

// File: rtl/sdram_line_cache.sv
// Single-line write-back byte cache turning host byte accesses into 8-byte SDRAM bursts.
module sdram_line_cache
  import sdram_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_BYTES = sdram_cache_pkg::LINE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [7:0]        host_wdata,
  input  logic              host_wren,
  input  logic              host_req,
  input  logic              host_flush,
  output logic              host_busy,
  output logic              host_done,
  output logic [7:0]        host_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  output logic              mem_req,
  output logic              mem_wren,
  input  logic              mem_ready,
  input  logic [2:0]        mem_offset,
  input  logic [7:0]        mem_rdata
);
  localparam int TAG_BITS = ADDR_W - IDX_W;

  state_t state, state_nx;
  logic                valid, dirty, seen_ready;
  logic [TAG_BITS-1:0] tag, lat_tag, host_tag, fill_tag;
  logic [IDX_W-1:0]    lat_idx;
  logic [7:0]          lat_wdata, line_rdata;
  logic                lat_wren, lat_flush;
  logic                hit, mem_done;

  assign host_tag = host_address[ADDR_W-1:IDX_W];
  assign hit      = valid && (tag == host_tag);
  assign mem_done = seen_ready && !mem_ready;
  assign fill_tag = (state == S_IDLE) ? host_tag : lat_tag;

  sdram_line_buf #(.DEPTH(LINE_BYTES)) u_line (
    .clk     (clk),
    .a_we    (state == S_HIT && lat_wren && !lat_flush),
    .a_idx   (lat_idx),
    .a_wdata (lat_wdata),
    .a_rdata (line_rdata),
    .b_we    (state == S_FILL_WAIT && mem_ready),
    .b_idx   (mem_offset),
    .b_wdata (mem_rdata),
    .b_rdata (mem_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // A clean flush passes through S_HIT as a no-op so every short path takes two cycles.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (host_flush)
          state_nx = (valid && dirty) ? S_EVICT_REQ : S_HIT;
        else if (host_req) begin
          if (hit)                 state_nx = S_HIT;
          else if (valid && dirty) state_nx = S_EVICT_REQ;
          else                     state_nx = S_FILL_REQ;
        end
      end
      S_HIT:        state_nx = S_DONE;
      S_EVICT_REQ:  state_nx = S_EVICT_WAIT;
      S_EVICT_WAIT: if (mem_done) state_nx = lat_flush ? S_DONE : S_FILL_REQ;
      S_FILL_REQ:   state_nx = S_FILL_WAIT;
      S_FILL_WAIT:  if (mem_done) state_nx = S_HIT;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    host_busy = 1'b1;
    host_done = 1'b0;
    mem_req   = 1'b0;
    case (state)
      S_IDLE:                  host_busy = 1'b0;
      S_DONE:      begin host_busy = 1'b0; host_done = 1'b1; end
      S_EVICT_REQ, S_FILL_REQ: mem_req   = 1'b1;
      default:                 host_busy = 1'b1;
    endcase
  end

  // Controller-side address is loaded on entry to a request state and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      dirty       <= 1'b0;
      tag         <= '0;
      lat_tag     <= '0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      lat_wren    <= 1'b0;
      lat_flush   <= 1'b0;
      seen_ready  <= 1'b0;
      host_rdata  <= '0;
      mem_address <= '0;
      mem_wren    <= 1'b0;
    end else begin
      if (state == S_IDLE && (host_flush || host_req)) begin
        lat_tag   <= host_tag;
        lat_idx   <= host_address[IDX_W-1:0];
        lat_wdata <= host_wdata;
        lat_wren  <= host_wren;
        lat_flush <= host_flush;
      end
      if (state == S_EVICT_REQ || state == S_FILL_REQ)
        seen_ready <= 1'b0;
      else if ((state == S_EVICT_WAIT || state == S_FILL_WAIT) && mem_ready)
        seen_ready <= 1'b1;
      if (state != S_EVICT_REQ && state_nx == S_EVICT_REQ) begin
        mem_address <= {tag, {IDX_W{1'b0}}};
        mem_wren    <= 1'b1;
      end else if (state != S_FILL_REQ && state_nx == S_FILL_REQ) begin
        mem_address <= {fill_tag, {IDX_W{1'b0}}};
        mem_wren    <= 1'b0;
      end
      if (state == S_EVICT_WAIT && mem_done)
        dirty <= 1'b0;
      if (state == S_FILL_WAIT && mem_done) begin
        valid <= 1'b1;
        tag   <= lat_tag;
      end
      if (state == S_HIT && !lat_flush) begin
        if (lat_wren) dirty      <= 1'b1;
        else          host_rdata <= line_rdata;
      end
    end
  end
endmodule

// File: tb/tb_sdram_line_cache.sv
// Directed bench: a burst controller model plus a table of host accesses with hand-computed results.
module tb_sdram_line_cache;
  localparam int AW = 21;

  logic          clk, rst;
  logic [AW-1:0] host_address, mem_address;
  logic [7:0]    host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic          host_wren, host_req, host_flush, host_busy, host_done;
  logic          mem_req, mem_wren, mem_ready;
  logic [2:0]    mem_offset;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] txn_addr [64];
  logic          txn_wren [64];
  int            txn_n = 0;
  logic          model_busy = 1'b0;
  logic          cur_wren;
  logic [63:0]   evict_line = '0;
  int            wide_err = 0;
  logic          prev_req = 1'b0;

  sdram_line_cache dut (
    .clk          (clk),
    .rst          (rst),
    .host_address (host_address),
    .host_wdata   (host_wdata),
    .host_wren    (host_wren),
    .host_req     (host_req),
    .host_flush   (host_flush),
    .host_busy    (host_busy),
    .host_done    (host_done),
    .host_rdata   (host_rdata),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_req      (mem_req),
    .mem_wren     (mem_wren),
    .mem_ready    (mem_ready),
    .mem_offset   (mem_offset),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Controller model: one idle cycle after the request, then 8 ready cycles returning 8'h10+offset.
  initial begin
    mem_ready = 1'b0; mem_offset = '0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        model_busy = 1'b1;
        cur_wren   = mem_wren;
        if (txn_n < 64) begin
          txn_addr[txn_n] = mem_address;
          txn_wren[txn_n] = mem_wren;
        end
        txn_n++;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          mem_ready  = 1'b1;
          mem_offset = 3'(i);
          mem_rdata  = 8'h10 + 8'(i);
          @(negedge clk);
          if (cur_wren) evict_line[8*i +: 8] = mem_wdata;
        end
        mem_ready  = 1'b0;
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && prev_req) wide_err++;
      prev_req = mem_req;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; latency counts clock edges from acceptance to host_done.
  task automatic applyStimulus(input logic flush, input logic req, input logic wren,
                               input logic [AW-1:0] addr, input logic [7:0] wdata,
                               output int lat, output logic timed_out);
    host_flush = flush; host_req = req; host_wren = wren;
    host_address = addr; host_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_done && lat < 200);
    timed_out  = !host_done;
    host_req   = 1'b0;
    host_flush = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    string         name;
    logic          flush, req, wren;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    int            exp_lat, exp_reqs;
    logic [AW-1:0] addr0;
    logic          wren0;
    logic [AW-1:0] addr1;
    logic [7:0]    exp_rdata;
    logic          chk_ev;
    logic [63:0]   exp_ev;
    logic          exp_dirty;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat, base, d0, d1, n;
    logic to;

    vecs[0] = '{"rd_miss",        0,1,0, 21'h000005, 8'h00, 12, 1, 21'h000000, 0, 21'h0, 8'h15, 0, 64'h0, 0};
    vecs[1] = '{"rd_hit",         0,1,0, 21'h000002, 8'h00,  2, 0, 21'h0,      0, 21'h0, 8'h12, 0, 64'h0, 0};
    vecs[2] = '{"wr_hit",         0,1,1, 21'h000003, 8'hA5,  2, 0, 21'h0,      0, 21'h0, 8'h12, 0, 64'h0, 1};
    vecs[3] = '{"wr_dirty_miss",  0,1,1, 21'h000013, 8'h00, 22, 2, 21'h000000, 1, 21'h000010, 8'h12, 1, 64'h17161514A5121110, 1};
    vecs[4] = '{"flush_dirty",    1,0,0, 21'h000013, 8'h00, 11, 1, 21'h000010, 1, 21'h0, 8'h12, 1, 64'h1716151400121110, 0};
    vecs[5] = '{"flush_clean",    1,0,0, 21'h000013, 8'h00,  2, 0, 21'h0,      0, 21'h0, 8'h12, 0, 64'h0, 0};
    vecs[6] = '{"wr_hit2",        0,1,1, 21'h000011, 8'h77,  2, 0, 21'h0,      0, 21'h0, 8'h12, 0, 64'h0, 1};
    vecs[7] = '{"flush_and_req",  1,1,0, 21'h000016, 8'h00, 11, 1, 21'h000010, 1, 21'h0, 8'h12, 1, 64'h1716151400127710, 0};
    vecs[8] = '{"rd_after_flush", 0,1,0, 21'h000016, 8'h00,  2, 0, 21'h0,      0, 21'h0, 8'h16, 0, 64'h0, 0};
    vecs[9] = '{"rd_top_addr",    0,1,0, 21'h1FFFFF, 8'h00, 12, 1, 21'h1FFFF8, 0, 21'h0, 8'h17, 0, 64'h0, 0};

    rst = 1'b0;
    host_address = '0; host_wdata = '0; host_wren = 1'b0; host_req = 1'b0; host_flush = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",  host_busy,   0);
    checkOutput("reset_done",  host_done,   0);
    checkOutput("reset_rdata", host_rdata,  0);
    checkOutput("reset_mreq",  mem_req,     0);
    checkOutput("reset_mwren", mem_wren,    0);
    checkOutput("reset_maddr", mem_address, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      base = txn_n;
      applyStimulus(vecs[i].flush, vecs[i].req, vecs[i].wren, vecs[i].addr, vecs[i].wdata, lat, to);
      checkOutput({vecs[i].name, "_timeout"}, to, 0);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].exp_lat);
      checkOutput({vecs[i].name, "_mem_reqs"}, txn_n - base, vecs[i].exp_reqs);
      checkOutput({vecs[i].name, "_rdata"}, host_rdata, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_dirty"}, dut.dirty, vecs[i].exp_dirty);
      if (vecs[i].exp_reqs >= 1 && txn_n > base && base < 64) begin
        checkOutput({vecs[i].name, "_addr0"}, txn_addr[base], vecs[i].addr0);
        checkOutput({vecs[i].name, "_wren0"}, txn_wren[base], vecs[i].wren0);
      end
      if (vecs[i].exp_reqs == 2 && txn_n > base + 1 && base < 63) begin
        checkOutput({vecs[i].name, "_addr1"}, txn_addr[base+1], vecs[i].addr1);
        checkOutput({vecs[i].name, "_wren1"}, txn_wren[base+1], 0);
      end
      if (vecs[i].chk_ev)
        checkOutput({vecs[i].name, "_evict_data"}, evict_line, vecs[i].exp_ev);
    end

    // Reset asserted mid-fill while the controller keeps bursting into an idle cache.
    base = txn_n;
    host_address = 21'h000040; host_wren = 1'b0; host_req = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy",  host_busy,   0);
    checkOutput("midrst_done",  host_done,   0);
    checkOutput("midrst_rdata", host_rdata,  0);
    checkOutput("midrst_mreq",  mem_req,     0);
    checkOutput("midrst_mwren", mem_wren,    0);
    checkOutput("midrst_maddr", mem_address, 0);
    host_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (model_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_model_idle", model_busy, 0);
    checkOutput("midrst_busy_after_ready", host_busy, 0);
    checkOutput("midrst_aborted_reqs", txn_n - base, 1);
    base = txn_n;
    applyStimulus(1'b0, 1'b1, 1'b0, 21'h000040, 8'h00, lat, to);
    checkOutput("refill_timeout", to, 0);
    checkOutput("refill_latency", lat, 12);
    checkOutput("refill_mem_reqs", txn_n - base, 1);
    if (txn_n > base && base < 64)
      checkOutput("refill_addr", txn_addr[base], 21'h000040);
    checkOutput("refill_rdata", host_rdata, 8'h10);

    // A held read request on a resident line completes once every three cycles.
    base = txn_n;
    host_address = 21'h000041; host_wren = 1'b0; host_req = 1'b1;
    d0 = -1; d1 = -1;
    for (int k = 1; k <= 40 && d1 < 0; k++) begin
      @(negedge clk);
      if (host_done) begin
        if (d0 < 0) d0 = k;
        else        d1 = k;
      end
    end
    host_req = 1'b0;
    @(negedge clk);
    checkOutput("b2b_first_done", d0, 2);
    checkOutput("b2b_spacing", d1 - d0, 3);
    checkOutput("b2b_rdata", host_rdata, 8'h11);
    checkOutput("b2b_mem_reqs", txn_n - base, 0);

    checkOutput("mem_req_pulse_width", wide_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
